lbp_host_port: RTL



---
 rtl/lbp_pkg.sv | 32 +++
 rtl/lbp_res_wr_stage.sv | 60 ++++++
 rtl/lbp_host_port.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lbp_pkg.sv
// Shared constants, FSM state encoding and the border-address helper for the
// LBP host port.
package lbp_pkg;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 8;
  localparam int IMG_W      = 128;
  localparam int EXP_WRITES = (IMG_W - 2) * (IMG_W - 2);

  // Column index width; the row index occupies the remaining upper bits.
  localparam int COL_W = $clog2(IMG_W);

  localparam logic [ADDR_W-1:0] WR_MAX  = '1;
  localparam logic [ADDR_W-1:0] EXP_CNT = ADDR_W'(EXP_WRITES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } lbp_state_t;

  // True when the row-major address sits on the first/last row or column.
  function automatic logic is_border(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-COL_W-1:0] row;
    logic [COL_W-1:0]        col;
    row = a[ADDR_W-1:COL_W];
    col = a[COL_W-1:0];
    return (row == '0) || (row == '1) || (col == '0) || (col == '1);
  endfunction

endpackage

// File: rtl/lbp_res_wr_stage.sv
// Result write capture: registers an accepted LBP write onto the result SRAM
// port (one cycle latency) and keeps a saturating count of accepted writes.
module lbp_res_wr_stage
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              accept,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_wdata,
  output logic [ADDR_W-1:0] wr_count
);

  logic              res_we_q,    res_we_d;
  logic [ADDR_W-1:0] res_addr_q,  res_addr_d;
  logic [DATA_W-1:0] res_wdata_q, res_wdata_d;
  logic [ADDR_W-1:0] wr_count_q,  wr_count_d;

  // Next write strobe/address/data and saturating write counter.
  always_comb begin
    res_we_d    = accept;
    res_addr_d  = res_addr_q;
    res_wdata_d = res_wdata_q;
    wr_count_d  = wr_count_q;
    if (accept) begin
      res_addr_d  = addr;
      res_wdata_d = data;
    end
    if (clr) begin
      wr_count_d = '0;
    end else if (accept && (wr_count_q != WR_MAX)) begin
      wr_count_d = wr_count_q + 1'b1;
    end
  end

  // Capture registers; reset drops any write still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_we_q    <= 1'b0;
      res_addr_q  <= '0;
      res_wdata_q <= '0;
      wr_count_q  <= '0;
    end else begin
      res_we_q    <= res_we_d;
      res_addr_q  <= res_addr_d;
      res_wdata_q <= res_wdata_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign res_we    = res_we_q;
  assign res_addr  = res_addr_q;
  assign res_wdata = res_wdata_q;
  assign wr_count  = wr_count_q;

endmodule

// File: rtl/lbp_host_port.sv
// Host-side responder for the LBP engine: serves image reads from a
// synchronous image SRAM, forwards result writes to the result SRAM, tracks
// frame completion and raises a sticky protocol error.
// Optional build macro LBP_BORDER_CHECK_EN: flag accepted writes whose address
// lies on the image border.
module lbp_host_port
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic              gray_ready,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              img_rd,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [DATA_W-1:0] img_rdata,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] wr_count,
  output logic              err
);

  lbp_state_t        state_q, state_d;
  logic              gray_ready_q, gray_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] gray_data_q, gray_data_d;
  logic              err_q, err_d;
  logic              enter_serve;
  logic              accept;
  logic [ADDR_W-1:0] final_cnt;

  // Next state, per-state outputs (registered from the next state) and the
  // frame-start clear.
  always_comb begin
    state_d     = state_q;
    enter_serve = 1'b0;
    unique case (state_q)
      IDLE:  if (start) begin state_d = SERVE; enter_serve = 1'b1; end
      SERVE: if (finish) state_d = DRAIN;
      DRAIN: state_d = DONE;
      DONE:  if (start) begin state_d = SERVE; enter_serve = 1'b1; end
      default: state_d = IDLE;
    endcase
    gray_ready_d = (state_d == SERVE);
    busy_d       = (state_d == SERVE) || (state_d == DRAIN);
    done_d       = (state_d == DONE);
  end

  // Read path: SRAM read is issued combinationally; the returned byte is
  // registered in the cycle the SRAM presents it, and held otherwise.
  assign img_rd   = gray_req & gray_ready_q;
  assign img_addr = gray_addr;

  always_comb begin
    rd_pend_d   = img_rd;
    gray_data_d = rd_pend_q ? img_rdata : gray_data_q;
  end

  // Write acceptance, final-count check and sticky error.
  assign accept = lbp_valid && (state_q == SERVE);

  always_comb begin
    final_cnt = (accept && (wr_count != WR_MAX)) ? wr_count + 1'b1 : wr_count;
    err_d     = err_q;
    if (enter_serve) err_d = 1'b0;
    if (lbp_valid && (state_q != SERVE)) err_d = 1'b1;
    if ((state_q == SERVE) && finish && (final_cnt != EXP_CNT)) err_d = 1'b1;
`ifdef LBP_BORDER_CHECK_EN
    if (accept && is_border(lbp_addr)) err_d = 1'b1;
`endif
  end

  // Control and read-data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      gray_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_pend_q    <= 1'b0;
      gray_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gray_ready_q <= gray_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_pend_q    <= rd_pend_d;
      gray_data_q  <= gray_data_d;
      err_q        <= err_d;
    end
  end

  lbp_res_wr_stage u_res_wr (
    .clk       (clk),
    .reset_n   (reset_n),
    .accept    (accept),
    .clr       (enter_serve),
    .addr      (lbp_addr),
    .data      (lbp_data),
    .res_we    (res_we),
    .res_addr  (res_addr),
    .res_wdata (res_wdata),
    .wr_count  (wr_count)
  );

  assign gray_ready = gray_ready_q;
  assign gray_data  = gray_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
